wishbone_mem_responder: RTL and testbench

Wishbone B4 classic responder (slave) backed by a single-port word-addressed RAM. It terminates the CPU-side Wishbone masters (instruction bus, data bus or combined bus) in simulation benches and small SoC builds. Latency is programmable, out-of-window accesses are answered with `err`, and aborted cycles are handled cleanly.

---
 rtl/wishbone_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_wishbone_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_mem_responder.sv
// Wishbone B4 classic responder backed by a word-addressed single-port RAM.
// Requests are captured in IDLE, optionally delayed by WAIT_STATES cycles,
// then terminated with a single-cycle ack (in window) or err (out of window).
module wishbone_mem_responder #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [29:0] BASE_WORD_ADDR = 30'h0,
    parameter int unsigned WAIT_STATES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic        wb_cti,
    input  logic        wb_bte,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        busy
);

    localparam int unsigned ADR_W  = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Storage: contents survive reset and are not initialised.
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]  dat_w_q, dat_w_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;
    logic               in_range_q, in_range_d;
    logic [DATA_W-1:0]  dat_r_q, dat_r_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               req_c;
    logic [ADR_W-1:0]   off_in_c;
    logic               in_range_in_c;
    logic [ADR_W-1:0]   cur_adr_c;
    logic [ADR_W-1:0]   cur_off_c;
    logic [IDX_W-1:0]   cur_idx_c;
    logic [DATA_W-1:0]  cur_dat_c;
    logic [SEL_W-1:0]   cur_sel_c;
    logic               cur_we_c;
    logic               cur_in_range_c;
    logic               resp_go_c;
    logic               mem_we_c;
    logic               unused_sink;

    // Address window decode; below-base addresses wrap to large offsets.
    always_comb begin
        req_c         = wb_cyc & wb_stb;
        off_in_c      = wb_adr - BASE_WORD_ADDR;
        in_range_in_c = ({1'b0, off_in_c} < (ADR_W + 1)'(DEPTH_WORDS));
    end

    // With zero wait states the commit happens on the accept edge, so the
    // live bus fields are used in IDLE and the captured copies otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_adr_c      = wb_adr;
            cur_dat_c      = wb_dat_w;
            cur_sel_c      = wb_sel;
            cur_we_c       = wb_we;
            cur_in_range_c = in_range_in_c;
        end else begin
            cur_adr_c      = adr_q;
            cur_dat_c      = dat_w_q;
            cur_sel_c      = sel_q;
            cur_we_c       = we_q;
            cur_in_range_c = in_range_q;
        end
        cur_off_c = cur_adr_c - BASE_WORD_ADDR;
        cur_idx_c = cur_off_c[IDX_W-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_w_d    = dat_w_q;
        sel_d      = sel_q;
        we_d       = we_q;
        in_range_d = in_range_q;
        dat_r_d    = dat_r_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        resp_go_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    adr_d      = wb_adr;
                    dat_w_d    = wb_dat_w;
                    sel_d      = wb_sel;
                    we_d       = wb_we;
                    in_range_d = in_range_in_c;
                    cnt_d      = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        resp_go_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        resp_go_c = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (resp_go_c) begin
            state_d = ST_RESP;
            ack_d   = cur_in_range_c;
            err_d   = ~cur_in_range_c;
            if (!cur_in_range_c) begin
                dat_r_d = '0;
            end else if (!cur_we_c) begin
                dat_r_d = mem[cur_idx_c];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Write strobe is suppressed while reset is asserted.
    always_comb begin
        mem_we_c = resp_go_c & cur_in_range_c & cur_we_c & ~rst;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            dat_w_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            dat_r_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            dat_w_q    <= dat_w_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            in_range_q <= in_range_d;
            dat_r_q    <= dat_r_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Byte-masked RAM write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(SEL_W); b++) begin
                if (cur_sel_c[b]) begin
                    mem[cur_idx_c][8*b +: 8] <= cur_dat_c[8*b +: 8];
                end
            end
        end
    end

    // Burst hints are ignored; upper offset bits only matter for the window test.
    assign unused_sink = ^{wb_cti, wb_bte, cur_off_c};

    assign wb_dat_r = dat_r_q;
    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wishbone_mem_responder.sv
// Scoreboard bench: four responders with different wait-state settings, a
// behavioural memory model, and per-instance monitors that pop expectations.
module tb_wishbone_mem_responder;

    localparam int unsigned N_INST = 4;
    localparam int unsigned DEPTH  = 64;
    localparam logic [29:0] BASE   = 30'h100;
    localparam int unsigned WS_TAB [N_INST] = '{32'd0, 32'd1, 32'd3, 32'd4};
    localparam int          TMO    = 40;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cti = 1'b0;
    logic        bte = 1'b0;

    logic [29:0] adr_a  [N_INST];
    logic [31:0] datw_a [N_INST];
    logic [3:0]  sel_a  [N_INST];
    logic        cyc_a  [N_INST];
    logic        stb_a  [N_INST];
    logic        we_a   [N_INST];
    logic [31:0] datr_a [N_INST];
    logic        ack_a  [N_INST];
    logic        err_a  [N_INST];
    logic        busy_a [N_INST];

    exp_t        exp_q [N_INST][$];
    logic [31:0] model_mem [N_INST][DEPTH];
    bit          prev_keep [N_INST];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    generate
        for (genvar g = 0; g < int'(N_INST); g++) begin : g_dut
            wishbone_mem_responder #(
                .DEPTH_WORDS   (DEPTH),
                .BASE_WORD_ADDR(BASE),
                .WAIT_STATES   (WS_TAB[g])
            ) dut (
                .clk     (clk),
                .rst     (rst),
                .wb_adr  (adr_a[g]),
                .wb_dat_w(datw_a[g]),
                .wb_sel  (sel_a[g]),
                .wb_cyc  (cyc_a[g]),
                .wb_stb  (stb_a[g]),
                .wb_we   (we_a[g]),
                .wb_cti  (cti),
                .wb_bte  (bte),
                .wb_dat_r(datr_a[g]),
                .wb_ack  (ack_a[g]),
                .wb_err  (err_a[g]),
                .busy    (busy_a[g])
            );

            // Monitor: every termination must match the oldest expectation.
            always @(negedge clk) begin : mon
                exp_t e;
                if (ack_a[g] || err_a[g]) begin
                    check($sformatf("inst%0d ack_err_exclusive", g), 32'(ack_a[g] & err_a[g]), 32'd0);
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst%0d unexpected_response: got ack=%0d err=%0d expected none",
                                 g, ack_a[g], err_a[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("inst%0d err", g), 32'(err_a[g]), 32'(e.err));
                        check($sformatf("inst%0d ack", g), 32'(ack_a[g]), 32'(!e.err));
                        if (e.chk) begin
                            check($sformatf("inst%0d dat_r", g), datr_a[g], e.dat);
                        end
                    end
                end
            end
        end
    endgenerate

    // Issue one access at a negedge, update the model, wait for termination.
    task automatic issue(input int i, input bit we, input logic [29:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input bit keep);
        exp_t e;
        int   lat;
        int   want;
        bit   inr;
        int   idx;
        inr   = (adr >= BASE) && (32'(adr) < 32'(BASE) + DEPTH);
        idx   = int'(adr - BASE);
        e.err = !inr;
        e.chk = !we || !inr;
        e.dat = 32'h0;
        if (inr) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) model_mem[i][idx][8*b +: 8] = dat[8*b +: 8];
                end
            end else begin
                e.dat = model_mem[i][idx];
            end
        end
        exp_q[i].push_back(e);
        want      = int'(WS_TAB[i]) + (prev_keep[i] ? 2 : 1);
        adr_a[i]  = adr;
        datw_a[i] = dat;
        sel_a[i]  = sel;
        we_a[i]   = we;
        cyc_a[i]  = 1'b1;
        stb_a[i]  = 1'b1;
        cti       = 1'($urandom);
        bte       = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack_a[i] || err_a[i]) && lat < TMO);
        check($sformatf("inst%0d latency adr=%h", i, adr), 32'(lat), 32'(want));
        prev_keep[i] = keep;
        if (!keep) begin
            cyc_a[i] = 1'b0;
            stb_a[i] = 1'b0;
            @(negedge clk);
        end
    endtask

    // Start a write, drop cyc two cycles later, expect no termination.
    task automatic abort_write(input int i, input logic [29:0] adr, input logic [31:0] dat);
        int resp;
        adr_a[i]  = adr;
        datw_a[i] = dat;
        sel_a[i]  = 4'hF;
        we_a[i]   = 1'b1;
        cyc_a[i]  = 1'b1;
        stb_a[i]  = 1'b1;
        resp = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack_a[i] || err_a[i]) resp++;
        end
        cyc_a[i] = 1'b0;
        stb_a[i] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack_a[i] || err_a[i]) resp++;
        end
        check($sformatf("inst%0d abort_no_response", i), 32'(resp), 32'd0);
        check($sformatf("inst%0d abort_busy", i), 32'(busy_a[i]), 32'd0);
        prev_keep[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(N_INST); i++) begin
            adr_a[i] = '0; datw_a[i] = '0; sel_a[i] = '0;
            cyc_a[i] = 1'b0; stb_a[i] = 1'b0; we_a[i] = 1'b0;
            prev_keep[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values.
        for (int i = 0; i < int'(N_INST); i++) begin
            check($sformatf("inst%0d reset ack", i), 32'(ack_a[i]), 32'd0);
            check($sformatf("inst%0d reset err", i), 32'(err_a[i]), 32'd0);
            check($sformatf("inst%0d reset busy", i), 32'(busy_a[i]), 32'd0);
            check($sformatf("inst%0d reset dat_r", i), datr_a[i], 32'd0);
        end

        // Preload every word of every instance over the bus.
        for (int i = 0; i < int'(N_INST); i++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                issue(i, 1'b1, BASE + 30'(w), $urandom, 4'hF, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a WAIT (3 wait states).
        issue(2, 1'b1, BASE + 30'd3, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(2, 1'b0, BASE + 30'd3, 32'h0, 4'hF, 1'b0);
        check("inst2 dat_r before reset", datr_a[2], 32'hCAFEF00D);
        adr_a[2] = BASE + 30'd7; we_a[2] = 1'b0; cyc_a[2] = 1'b1; stb_a[2] = 1'b1;
        @(negedge clk);
        check("inst2 busy in wait", 32'(busy_a[2]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("inst2 async reset busy", 32'(busy_a[2]), 32'd0);
        check("inst2 async reset ack", 32'(ack_a[2]), 32'd0);
        check("inst2 async reset err", 32'(err_a[2]), 32'd0);
        check("inst2 async reset dat_r", datr_a[2], 32'd0);
        cyc_a[2] = 1'b0; stb_a[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(2, 1'b0, BASE + 30'd3, 32'h0, 4'hF, 1'b0);

        // Byte-enable write then read (1 wait state).
        issue(1, 1'b1, BASE, 32'hAABBCCDD, 4'hF, 1'b0);
        issue(1, 1'b1, BASE, 32'h11223344, 4'b0101, 1'b0);
        issue(1, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
        check("inst1 byte merge", datr_a[1], 32'hAA22CC44);
        issue(1, 1'b1, BASE, 32'h55555555, 4'b0000, 1'b0);
        issue(1, 1'b0, BASE, 32'h0, 4'hF, 1'b0);

        // Out-of-window accesses on every instance.
        for (int i = 0; i < int'(N_INST); i++) begin
            issue(i, 1'b0, 30'h0FF, 32'h0, 4'hF, 1'b0);
            issue(i, 1'b1, BASE + 30'(DEPTH), 32'h12345678, 4'hF, 1'b0);
            issue(i, 1'b0, BASE + 30'(DEPTH - 1), 32'h0, 4'hF, 1'b0);
        end

        // Aborted write (4 wait states) leaves the word intact.
        abort_write(3, BASE + 30'd5, 32'hDEADBEEF);
        issue(3, 1'b0, BASE + 30'd5, 32'h0, 4'hF, 1'b0);

        // Back-to-back reads with cyc/stb held (0 wait states).
        for (int k = 0; k < 4; k++) begin
            issue(0, 1'b0, BASE + 30'(8 + k), 32'h0, 4'hF, k != 3);
        end

        // Terminal word: write/read, and word 0 must not alias.
        for (int i = 0; i < int'(N_INST); i++) begin
            issue(i, 1'b1, BASE + 30'(DEPTH - 1), $urandom, 4'hF, 1'b0);
            issue(i, 1'b0, BASE + 30'(DEPTH - 1), 32'h0, 4'hF, 1'b0);
            issue(i, 1'b0, BASE, 32'h0, 4'hF, 1'b0);
        end

        // Randomized mix of reads, writes, sel patterns and window misses.
        for (int i = 0; i < int'(N_INST); i++) begin
            for (int n = 0; n < 60; n++) begin
                logic [29:0] a;
                int          r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      a = 30'($urandom_range(0, 32'(BASE) - 1));
                else if (r == 1) a = BASE + 30'(DEPTH) + 30'($urandom_range(0, 1000));
                else if (r == 2) a = 30'h3FFFFFFF;
                else             a = BASE + 30'($urandom_range(0, DEPTH - 1));
                issue(i, 1'($urandom), a, $urandom, 4'($urandom),
                      (n != 59) && ($urandom_range(0, 3) == 0));
            end
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < int'(N_INST); i++) begin
            check($sformatf("inst%0d scoreboard drained", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
